// File: rtl/i2s_pkg.sv
// Shared I2S constants and helpers.
// Used by both the transmit and receive paths.
package i2s_pkg;

   localparam logic [1:0] CH_LEFT   = 2'b10;
   localparam logic [1:0] CH_RIGHT  = 2'b01;
   localparam logic [1:0] CH_STEREO = 2'b11;

   localparam int   SLOT_BITS = 32;
   localparam int   CTR_W     = $clog2(SLOT_BITS);
   localparam logic WS_LEFT   = 1'b0;

   // 0 and anything above 32 mean a full 32-bit word
   function automatic logic [5:0] eff_size(input logic [5:0] s);
      return (s == 6'd0 || s > 6'd32) ? 6'd32 : s;
   endfunction

   // MSB-align a right-aligned word; bits above size fall off the top
   function automatic logic [31:0] align(input logic [31:0] w,
                                         input logic [5:0]  size);
      logic [5:0] sz;
      sz = eff_size(size);
      return w << (6'd32 - sz);
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock and word-select generator.
// Exports the SCK fall strobe and the in-slot bit counter.
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter int PW = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PW-1:0]    presc_i,
   output logic             sck_o,
   output logic             ws_o,
   output logic             fe_o,
   output logic [CTR_W-1:0] bit_ctr_o
);

   logic [PW-1:0]    presc_q, presc_d;
   logic             sck_q, sck_d;
   logic             ws_q, ws_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic             tick;
   logic             fe;

   assign tick = en & (presc_q == '0);
   assign fe   = tick & sck_q;

   // prescaler countdown, SCK toggle and slot/frame counting on falls
   always_comb begin
      presc_d = presc_q;
      sck_d   = sck_q;
      ctr_d   = ctr_q;
      ws_d    = ws_q;
      if (en) presc_d = tick ? presc_i : presc_q - 1'b1;
      if (tick) sck_d = ~sck_q;
      if (fe) begin
         ctr_d = ctr_q + 1'b1;
         if (ctr_q == '0) ws_d = ~ws_q;
      end
   end

   // clock-generator state; ws starts high so the first slot is left
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         sck_q   <= 1'b0;
         ws_q    <= 1'b1;
         ctr_q   <= '0;
      end else begin
         presc_q <= presc_d;
         sck_q   <= sck_d;
         ws_q    <= ws_d;
         ctr_q   <= ctr_d;
      end
   end

   assign sck_o     = sck_q;
   assign ws_o      = ws_q;
   assign fe_o      = fe;
   assign bit_ctr_o = ctr_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: hold register plus MSB-first serialiser.
// Clocking comes from i2s_clkgen; data moves only on SCK falls.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [PW-1:0] sck_prescaler,
   input  logic          left_justified,
   input  logic [5:0]    sample_size,
   input  logic [1:0]    channels,
   input  logic [31:0]   sample,
   input  logic          sample_valid,
   output logic          sample_ready,
   output logic          sck,
   output logic          ws,
   output logic          sd,
   output logic          underflow
);

   logic             fe;
   logic [CTR_W-1:0] bit_ctr;
   logic             slot_ws;
   logic             load;
   logic             ch_on;
   logic             accept;

   logic [31:0] hold_q, hold_d;
   logic        full_q, full_d;
   logic [31:0] sr_q, sr_d;
   logic        sd_q, sd_d;
   logic        uf_q, uf_d;

   i2s_clkgen #(.PW(PW)) u_clkgen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .presc_i   (sck_prescaler),
      .sck_o     (sck),
      .ws_o      (ws),
      .fe_o      (fe),
      .bit_ctr_o (bit_ctr)
   );

   // at bit 0 ws is about to toggle, so the slot is the inverted value
   assign slot_ws = (bit_ctr == '0) ? ~ws : ws;
   assign load    = fe & (left_justified ? (bit_ctr == 5'd0)
                                         : (bit_ctr == 5'd1));
   assign ch_on   = (slot_ws == WS_LEFT) ? |(channels & CH_LEFT)
                                         : |(channels & CH_RIGHT);
   assign accept  = sample_valid & ~full_q;

   // load/shift the serialiser and manage the single-entry hold register
   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      sr_d   = sr_q;
      sd_d   = sd_q;
      uf_d   = 1'b0;
      if (fe) begin
         if (load) begin
            if (ch_on && full_q) begin
               sr_d   = align(hold_q, sample_size);
               full_d = 1'b0;
            end else begin
               sr_d = '0;
               uf_d = ch_on;
            end
         end else begin
            sr_d = {sr_q[30:0], 1'b0};
         end
         sd_d = sr_d[31];
      end
      if (accept) begin
         hold_d = sample;
         full_d = 1'b1;
      end
   end

   // serialiser and hold state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         full_q <= 1'b0;
         sr_q   <= '0;
         sd_q   <= 1'b0;
         uf_q   <= 1'b0;
      end else begin
         hold_q <= hold_d;
         full_q <= full_d;
         sr_q   <= sr_d;
         sd_q   <= sd_d;
         uf_q   <= uf_d;
      end
   end

   assign sample_ready = ~full_q;
   assign sd           = sd_q;
   assign underflow    = uf_q;

endmodule
